count_mode_ctrl: RTL and testbench

- Upstream control stage for the 4-bit up/down counter.
- Converts a raw, bouncing pushbutton into a clean mode level (1 = up, 0 = down), a one-cycle mode-change pulse, and a periodic count-enable tick.
- The counter's mode input connects directly to this block's mode output; tick gates its counting.
- Single clock domain; the button input is asynchronous to it.

---
 rtl/count_mode_ctrl_pkg.sv | 20 ++
 rtl/count_mode_ctrl_tick.sv | 36 +++
 rtl/count_mode_ctrl.sv | 109 ++++++++++
 tb/tb_count_mode_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mode_ctrl_pkg.sv
// count_mode_ctrl_pkg: shared types and constants for the
// mode control stage, the up/down counter and their benches.
package count_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  // Counter width for a 0..n-1 range, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_mode_ctrl_tick.sv
// tick_divider: free-running count-enable divider with
// a restart input that re-phases it and kills the current tick.
module tick_divider
  import count_mode_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int W = cnt_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  // Count 0..TICK_DIV-1, pulse tick on wrap; restart wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/count_mode_ctrl.sv
// count_mode_ctrl: pushbutton synchronizer, debounce FSM and
// mode toggle, feeding a tick divider for the up/down counter.
module count_mode_ctrl
  import count_mode_ctrl_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter int   TICK_DIV        = 10,
  parameter logic MODE_INIT       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_clean,
  output logic mode,
  output logic mode_changed,
  output logic tick
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  // The entry sample counts as the first stable one, so the
  // wait states finish when the count hits DEBOUNCE_CYCLES-2.
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 2);

  logic [1:0]    sync;
  logic          btn_s;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic          accept;

  assign btn_s  = sync[1];
  assign accept = (state == PRESS_WAIT) && btn_s &&
                  (cnt == DB_LAST);

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], btn_raw};
    end
  end

  // Debounce FSM; toggles mode once per accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RELEASED;
      cnt          <= '0;
      btn_clean    <= 1'b0;
      mode         <= MODE_INIT;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (accept) begin
            state        <= PRESSED;
            cnt          <= '0;
            btn_clean    <= 1'b1;
            mode         <= ~mode;
            mode_changed <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state     <= RELEASED;
            cnt       <= '0;
            btn_clean <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .restart(accept),
    .tick   (tick)
  );

endmodule

// File: tb/tb_count_mode_ctrl.sv
// tb_count_mode_ctrl: directed plus random stimulus, window-based
// reference model and a per-cycle output scoreboard.
module tb_count_mode_ctrl;
  import count_mode_ctrl_pkg::*;

  localparam int DB = 16;
  localparam int TD = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_clean, mode, mode_changed, tick;

  always #5 clk = ~clk;

  count_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD),
    .MODE_INIT      (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .btn_clean   (btn_clean),
    .mode        (mode),
    .mode_changed(mode_changed),
    .tick        (tick)
  );

  typedef struct packed {
    logic m;
    logic c;
    logic chg;
    logic tk;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: the debounced level flips once the last DB
  // synchronized samples all disagree with it; a rising flip is a
  // toggle. Ticks fall every TD edges after the latest anchor
  // (reset release or toggle), never on the toggle edge itself.
  bit rawq[$];
  bit seenq[$];
  int n_edge = 0;
  int anchor = 0;
  bit lvl = 0;
  bit m_mode = 1;

  always @(posedge clk) begin
    bit seen, all_opp, tog, tk;
    if (!reset) begin
      rawq = {};
      rawq.push_back(1'b0);
      rawq.push_back(1'b0);
      seenq = {};
      n_edge = 0;
      anchor = 0;
      lvl = 1'b0;
      m_mode = MODE_UP;
      sbq.push_back('{MODE_UP, 1'b0, 1'b0, 1'b0});
    end else begin
      n_edge++;
      rawq.push_back(btn_raw);
      seen = rawq[rawq.size() - 3];
      while (rawq.size() > 3) void'(rawq.pop_front());
      seenq.push_back(seen);
      while (seenq.size() > DB) void'(seenq.pop_front());
      all_opp = (seenq.size() == DB);
      foreach (seenq[i]) if (seenq[i] == lvl) all_opp = 1'b0;
      tog = all_opp && !lvl;
      if (all_opp) lvl = ~lvl;
      if (tog) begin
        m_mode = ~m_mode;
        anchor = n_edge;
      end
      tk = !tog && (n_edge > anchor) &&
           (((n_edge - anchor) % TD) == 0);
      sbq.push_back('{m_mode, lvl, tog, tk});
    end
  end

  // Monitor: compare every post-edge output set against the model.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("outs{mode,clean,chg,tick}",
            {28'd0, mode, btn_clean, mode_changed, tick}, {28'd0, e});
    end
  end

  int gcyc = 0;
  int chg_seen = 0;
  int last_chg = -100;
  int last_tick = 0;
  int prev_tick = 0;
  int tick_after = 0;
  bit tick_at_chg = 0;

  // One clock: drive at the falling edge, observe after the rise.
  task automatic cyc(input bit v, input bit r = 1'b1);
    @(negedge clk);
    btn_raw = v;
    reset = r;
    @(posedge clk);
    #1;
    gcyc++;
    if (mode_changed === 1'b1) begin
      chg_seen++;
      last_chg = gcyc;
      tick_after = 0;
      if (tick === 1'b1) tick_at_chg = 1'b1;
    end
    if (tick === 1'b1) begin
      prev_tick = last_tick;
      last_tick = gcyc;
      if (tick_after == 0 && gcyc > last_chg) tick_after = gcyc;
    end
  endtask

  initial begin
    int t0, c0, idx1, idx2, lat, fall, due;
    bit v;
    // Reset and idle.
    #6;
    check("rst_mode", {31'd0, mode}, 32'd1);
    check("rst_clean", {31'd0, btn_clean}, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    cyc(1'b0, 1'b0);
    t0 = gcyc + 1;
    idx1 = 0;
    idx2 = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0);
      if (tick === 1'b1 && idx1 == 0) idx1 = gcyc - t0 + 1;
      else if (tick === 1'b1 && idx2 == 0) idx2 = gcyc - t0 + 1;
    end
    check("first_tick_cycle", idx1, TD);
    check("second_tick_cycle", idx2, 2 * TD);
    check("idle_no_chg", chg_seen, 0);

    // Clean press held 40 cycles.
    c0 = chg_seen;
    t0 = gcyc + 1;
    repeat (40) cyc(1'b1);
    lat = last_chg - t0 + 1;
    check("press_pulses", chg_seen - c0, 1);
    check("press_lat_in_17_19", (lat >= DB + 1 && lat <= DB + 3), 1);
    check("press_mode", {31'd0, mode}, 32'd0);
    check("press_clean", {31'd0, btn_clean}, 32'd1);
    repeat (25) cyc(1'b0);
    check("release_clean", {31'd0, btn_clean}, 32'd0);
    check("release_no_toggle", chg_seen - c0, 1);

    // Bounce rejection.
    c0 = chg_seen;
    for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 0);
    repeat (20) cyc(1'b0);
    check("bounce_pulses", chg_seen - c0, 0);
    check("bounce_mode", {31'd0, mode}, 32'd0);
    check("bounce_clean", {31'd0, btn_clean}, 32'd0);

    // Bouncy press then bouncy release.
    c0 = chg_seen;
    repeat (5) begin
      repeat (2) cyc(1'b1);
      repeat (2) cyc(1'b0);
    end
    repeat (30) cyc(1'b1);
    check("bouncy_press_pulses", chg_seen - c0, 1);
    check("bouncy_mode", {31'd0, mode}, 32'd1);
    repeat (4) begin
      repeat (2) cyc(1'b0);
      repeat (2) cyc(1'b1);
    end
    t0 = gcyc + 1;
    fall = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0);
      if (btn_clean === 1'b0 && fall == 0) fall = gcyc - t0 + 1;
    end
    check("bouncy_rel_lat_in_17_19",
          (fall >= DB + 1 && fall <= DB + 3), 1);
    check("bouncy_total_pulses", chg_seen - c0, 1);

    // Tick restart: land the toggle on a due tick.
    for (int i = 0; i < 12; i++)
      if (((gcyc + 1 + DB + 1 - last_tick) % TD) != 0) cyc(1'b0);
    c0 = chg_seen;
    tick_at_chg = 1'b0;
    repeat (40) cyc(1'b1);
    check("restart_pulses", chg_seen - c0, 1);
    due = ((last_chg - prev_tick) % TD == 0) ? 1 : 0;
    check("restart_tick_was_due", due, 1);
    check("restart_tick_dropped", tick_at_chg, 0);
    check("restart_next_tick_gap", tick_after - last_chg, TD);
    repeat (25) cyc(1'b0);

    // Reset mid-debounce.
    c0 = chg_seen;
    repeat (11) cyc(1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_mode", {31'd0, mode}, 32'd1);
    check("midrst_chg", {31'd0, mode_changed}, 32'd0);
    check("midrst_clean", {31'd0, btn_clean}, 32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("midrst_no_pulse", chg_seen - c0, 0);
    t0 = gcyc + 1;
    cyc(1'b1, 1'b1);
    repeat (29) cyc(1'b1);
    lat = last_chg - t0 + 1;
    check("midrst_fresh_pulses", chg_seen - c0, 1);
    check("midrst_fresh_lat_in_17_19",
          (lat >= DB + 1 && lat <= DB + 3), 1);
    repeat (25) cyc(1'b0);

    // Random runs with occasional resets; scoreboard checks all.
    v = 1'b0;
    for (int k = 0; k < 120; k++) begin
      v = ~v;
      repeat ($urandom_range(1, 24)) cyc(v);
      if ($urandom_range(0, 99) < 4) begin
        cyc(v, 1'b0);
        cyc(v, 1'b0);
      end
    end
    repeat (40) cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
